memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL use reset nRST, asynchronous, active-low, and clock CLK.
REQ-002 Parameter: STARVE_MAX, default 4, max consecutive data grants while iREN is pending.
REQ-003 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- iREN  in  1  instruction fetch request
- iaddr  in  32  fetch word address
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  write data
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- ramload  in  32  RAM read data
- ihit  out  1  fetch complete; this signal gates PC update
- iload  out  32  fetched instruction
- dhit  out  1  data access complete
- dload  out  32  data read result
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- err  out  1  sticky RAM error flag

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, IACC and DACC.
REQ-005 In IDLE, the block SHALL arbitrate on the requests sampled in that cycle and enter the granted state at the next edge.
- No RAM strobes are driven in IDLE.
REQ-006 Data requests (dREN|dWEN) SHALL have priority over iREN, except as stated in REQ-007.
REQ-007 A 3-bit starve counter SHALL behave as follows:
- Increments on each DACC grant made while iREN=1.
- Clears on any IACC grant, and on any DACC grant made with iREN=0.
- When the count equals STARVE_MAX and iREN=1, the next grant SHALL go to IACC regardless of data requests.
REQ-008 On grant, the block SHALL latch the address, plus dstore and the op type for DACC.
- ramaddr and ramstore SHALL come from these latched values, not from the live inputs.
REQ-009 If dREN and dWEN are both 1 at grant, the access SHALL be a write only (ramWEN=1, ramREN=0).
REQ-010 In IACC, ramREN=1 and ramWEN=0; in DACC, exactly one of ramREN/ramWEN SHALL be 1.
REQ-011 When ramstate=ACCESS in IACC, the block SHALL, in the same cycle:
- assert ihit=1 for exactly that cycle (combinational);
- drive iload=ramload;
- transition to IDLE at the next edge.
REQ-012 When ramstate=ACCESS in DACC, dhit SHALL be asserted the same way.
- dload=ramload for reads.
- dload=0 for writes.
REQ-013 In IACC/DACC with ramstate FREE or BUSY, the block SHALL hold its state and strobes with no hit.
REQ-014 If the granted request drops while its state is active (iREN=0 in IACC; dREN=dWEN=0 in DACC), the block SHALL:
- de-assert the strobes in that cycle;
- produce no hit;
- return to IDLE.
REQ-015 ramstate=ERROR in IACC/DACC SHALL abort the access: no hit, err set to 1, return to IDLE.
- err stays 1 until reset.
REQ-016 ihit and dhit SHALL never be 1 in the same cycle.
- When not hit, iload and dload SHALL be 0.
REQ-017 Minimum latency SHALL be:
- request in cycle N (IDLE), grant at edge N+1, hit in cycle N+1 if RAM returns ACCESS immediately;
- back-to-back accesses therefore complete at most every 2 cycles.

Reset
REQ-018 While nRST=0, the block SHALL force the following, asynchronously:
- state=IDLE, starve counter=0, err=0;
- latched address/data=0;
- all outputs 0.
REQ-019 Reset asserted mid-access SHALL discard the access with no hit.
- After release, the block SHALL re-arbitrate from IDLE on the first edge.

Verification
REQ-020 The bench SHALL cover at least these directed scenarios:
- iREN=1, iaddr=0x40, ramstate=ACCESS immediately, ramload=0x8C220004 -> ramREN=1, ramaddr=0x40 in cycle 1; ihit=1, iload=0x8C220004 for one cycle; IDLE in cycle 2.
- iREN=1 and dWEN=1 together, daddr=0x100, dstore=0xDEADBEEF, RAM BUSY 2 cycles then ACCESS -> DACC first; ramWEN=1, ramstore=0xDEADBEEF held 3 cycles; dhit pulses; IACC granted next.
- iREN held, dREN continuously re-asserted, RAM always ACCESS -> 4 data grants, then one IACC grant with ihit=1, counter cleared.
- DACC active, dREN dropped while RAM BUSY -> strobes low that cycle, no dhit, IDLE next edge.
- ramstate=ERROR during IACC -> no ihit, err=1 persisting through later successful accesses until nRST=0.
- nRST pulsed low during DACC with RAM BUSY -> all outputs 0 immediately, no dhit; pending iREN granted IACC one edge after release.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: single-port RAM arbiter between instruction fetch and data access.
// Data requests win unless fetch has waited STARVE_MAX consecutive data grants.
module memory_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [1:0]  ramstate,
  input  logic [31:0] ramload,
  output logic        ihit,
  output logic [31:0] iload,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  state_t      r_state, w_next;
  logic [2:0]  r_starve;
  logic        r_err, r_wr;
  logic [31:0] r_addr, r_data;
  logic        w_dreq, w_grant_i, w_grant_d, w_active, w_access, w_error;
  assign w_dreq    = dREN | dWEN;
  assign w_grant_i = iREN && (!w_dreq || r_starve == 3'(STARVE_MAX));
  assign w_grant_d = w_dreq && !w_grant_i;
  // The granted request must still be asserted for the access to stay alive.
  assign w_active  = (r_state == IACC) ? iREN : (r_state == DACC) ? w_dreq : 1'b0;
  assign w_access  = w_active && ramstate == RAM_ACCESS;
  assign w_error   = r_state != IDLE && ramstate == RAM_ERROR;
  assign err       = r_err;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_starve <= 3'd0;
      r_err    <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= 32'd0;
      r_data   <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && (w_grant_i || w_grant_d)) begin
        r_addr   <= w_grant_i ? iaddr : daddr;
        r_data   <= w_grant_i ? 32'd0 : dstore;
        r_wr     <= w_grant_d && dWEN;
        r_starve <= (w_grant_d && iREN) ? r_starve + 3'd1 : 3'd0;
      end
      if (w_error) r_err <= 1'b1;
    end
  end
  always_comb begin
    w_next   = r_state;
    ihit     = r_state == IACC && w_access;
    dhit     = r_state == DACC && w_access;
    iload    = (r_state == IACC && w_access) ? ramload : 32'd0;
    dload    = (r_state == DACC && w_access && !r_wr) ? ramload : 32'd0;
    ramREN   = w_active && (r_state == IACC || !r_wr);
    ramWEN   = w_active && r_state == DACC && r_wr;
    ramaddr  = (r_state == IDLE) ? 32'd0 : r_addr;
    ramstore = (r_state == DACC && r_wr) ? r_data : 32'd0;
    if (r_state == IDLE) w_next = w_grant_i ? IACC : w_grant_d ? DACC : IDLE;
    else if (!w_active || w_access || w_error) w_next = IDLE;
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenario bench for memory_arbiter.
module tb_memory_arbiter;
  logic        CLK = 1'b0, nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]  ramstate = 2'd0;
  logic        ihit, dhit, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  int vectors = 0, miscompares = 0;

  memory_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ramstate(ramstate), .ramload(ramload),
    .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload), .ramREN(ramREN),
    .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({ihit, dhit, ramREN, ramWEN, err} !== 5'b0 || ramaddr !== 32'd0 || ramstore !== 32'd0 || iload !== 32'd0 || dload !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got hits/strobes/err=%b addr=%h store=%h, need all zero", {ihit, dhit, ramREN, ramWEN, err}, ramaddr, ramstore);
    end
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_ifetch();
    iREN = 1'b1; iaddr = 32'h40; ramstate = 2'd2; ramload = 32'h8C220004;
    #1;
    vectors++;
    if ({ramREN, ihit} !== 2'b00) begin miscompares++; $display("FAIL ifetch_idle: ramREN/ihit=%b need 00", {ramREN, ihit}); end
    step();
    iaddr = 32'h44;
    #1;
    vectors++;
    if ({ramREN, ramWEN, ihit, dhit} !== 4'b1010 || ramaddr !== 32'h40 || iload !== 32'h8C220004) begin
      miscompares++;
      $display("FAIL ifetch_hit: strobes/hits=%b addr=%h iload=%h need 1010 40 8c220004", {ramREN, ramWEN, ihit, dhit}, ramaddr, iload);
    end
    iREN = 1'b0;
    step();
    vectors++;
    if ({ramREN, ihit} !== 2'b00 || iload !== 32'd0) begin miscompares++; $display("FAIL ifetch_after: ramREN/ihit=%b iload=%h need 00 0", {ramREN, ihit}, iload); end
  endtask

  task automatic test_write_priority();
    iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = 2'd1;
    step();
    dstore = 32'h12345678;
    for (int k = 0; k < 2; k++) begin
      #1;
      vectors++;
      if ({ramREN, ramWEN, dhit, ihit} !== 4'b0100 || ramstore !== 32'hDEADBEEF || ramaddr !== 32'h100) begin
        miscompares++;
        $display("FAIL write_busy%0d: strobes/hits=%b store=%h addr=%h need 0100 deadbeef 100", k, {ramREN, ramWEN, dhit, ihit}, ramstore, ramaddr);
      end
      step();
    end
    ramstate = 2'd2;
    #1;
    vectors++;
    if ({ramREN, ramWEN, dhit, ihit} !== 4'b0110 || ramstore !== 32'hDEADBEEF || dload !== 32'd0) begin
      miscompares++;
      $display("FAIL write_hit: strobes/hits=%b store=%h dload=%h need 0110 deadbeef 0", {ramREN, ramWEN, dhit, ihit}, ramstore, dload);
    end
    dWEN = 1'b0;
    step();
    step();
    vectors++;
    if ({ihit, dhit} !== 2'b10 || ramaddr !== 32'h80) begin miscompares++; $display("FAIL write_then_fetch: ihit/dhit=%b addr=%h need 10 80", {ihit, dhit}, ramaddr); end
    iREN = 1'b0;
    step();
  endtask

  task automatic test_both_ops();
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h104; dstore = 32'hCAFEF00D; ramstate = 2'd2; ramload = 32'h11111111;
    step();
    vectors++;
    if ({ramREN, ramWEN, dhit} !== 3'b011 || dload !== 32'd0 || ramstore !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL both_ops: ren/wen/dhit=%b dload=%h store=%h need 011 0 cafef00d", {ramREN, ramWEN, dhit}, dload, ramstore);
    end
    dREN = 1'b0; dWEN = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h200; ramload = 32'hA5A5A5A5; ramstate = 2'd2;
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++;
      if ({ramREN, ramWEN, dhit, ihit} !== 4'b1010 || dload !== 32'hA5A5A5A5 || ramaddr !== 32'h200 || iload !== 32'd0) begin
        miscompares++;
        $display("FAIL starve_data%0d: strobes/hits=%b dload=%h addr=%h need 1010 a5a5a5a5 200", k, {ramREN, ramWEN, dhit, ihit}, dload, ramaddr);
      end
      step();
    end
    step();
    vectors++;
    if ({ihit, dhit} !== 2'b10 || ramaddr !== 32'h80 || iload !== 32'hA5A5A5A5 || dload !== 32'd0) begin
      miscompares++;
      $display("FAIL starve_fetch: ihit/dhit=%b addr=%h need 10 80", {ihit, dhit}, ramaddr);
    end
    step();
    step();
    vectors++;
    if ({ihit, dhit} !== 2'b01) begin miscompares++; $display("FAIL starve_cleared: ihit/dhit=%b need 01", {ihit, dhit}); end
    iREN = 1'b0; dREN = 1'b0;
    step();
  endtask

  task automatic test_drop();
    dREN = 1'b1; daddr = 32'h300; ramstate = 2'd1;
    step();
    vectors++;
    if ({ramREN, ramWEN, dhit} !== 3'b100) begin miscompares++; $display("FAIL drop_busy: ren/wen/dhit=%b need 100", {ramREN, ramWEN, dhit}); end
    step();
    dREN = 1'b0;
    #1;
    vectors++;
    if ({ramREN, ramWEN, dhit} !== 3'b000) begin miscompares++; $display("FAIL drop_strobes: ren/wen/dhit=%b need 000", {ramREN, ramWEN, dhit}); end
    step();
    iREN = 1'b1; iaddr = 32'h90; ramstate = 2'd2;
    step();
    vectors++;
    if (ihit !== 1'b1 || ramaddr !== 32'h90) begin miscompares++; $display("FAIL drop_idle: ihit=%b addr=%h need 1 90", ihit, ramaddr); end
    iREN = 1'b0;
    step();
  endtask

  task automatic test_error();
    iREN = 1'b1; iaddr = 32'hA0; ramstate = 2'd3;
    step();
    vectors++;
    if ({ramREN, ihit} !== 2'b10 || err !== 1'b0) begin miscompares++; $display("FAIL error_cycle: ren/ihit=%b err=%b need 10 0", {ramREN, ihit}, err); end
    step();
    vectors++;
    if ({ramREN, ihit, err} !== 3'b001) begin miscompares++; $display("FAIL error_abort: ren/ihit/err=%b need 001", {ramREN, ihit, err}); end
    ramstate = 2'd2;
    step();
    vectors++;
    if ({ihit, err} !== 2'b11) begin miscompares++; $display("FAIL error_sticky: ihit/err=%b need 11", {ihit, err}); end
    iREN = 1'b0;
    step();
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL error_persist: err=%b need 1", err); end
  endtask

  task automatic test_reset_mid();
    dREN = 1'b1; daddr = 32'h400; iREN = 1'b1; iaddr = 32'hB0; ramstate = 2'd1;
    step();
    vectors++;
    if ({ramREN, dhit} !== 2'b10 || ramaddr !== 32'h400) begin miscompares++; $display("FAIL rstmid_grant: ren/dhit=%b addr=%h need 10 400", {ramREN, dhit}, ramaddr); end
    nRST = 1'b0;
    #1;
    vectors++;
    if ({ihit, dhit, ramREN, ramWEN, err} !== 5'b0 || ramaddr !== 32'd0 || ramstore !== 32'd0) begin
      miscompares++;
      $display("FAIL rstmid_async: hits/strobes/err=%b addr=%h need all zero", {ihit, dhit, ramREN, ramWEN, err}, ramaddr);
    end
    step();
    dREN = 1'b0; ramstate = 2'd2;
    #1 nRST = 1'b1;
    #1;
    vectors++;
    if ({ramREN, ihit, dhit} !== 3'b000) begin miscompares++; $display("FAIL rstmid_idle: ren/ihit/dhit=%b need 000", {ramREN, ihit, dhit}); end
    step();
    vectors++;
    if (ihit !== 1'b1 || ramaddr !== 32'hB0) begin miscompares++; $display("FAIL rstmid_refetch: ihit=%b addr=%h need 1 b0", ihit, ramaddr); end
    iREN = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    step();
    test_ifetch();
    test_write_priority();
    test_both_ops();
    test_starvation();
    test_drop();
    test_error();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
